// File: rtl/button_event_arbiter.sv
// Turns five debounced button levels into PRESS/RELEASE/LONG/REPEAT events,
// arbitrates them round-robin and queues them in a show-ahead FIFO.
module button_event_arbiter #(
  parameter int LONG_PRESS_CYCLES = 100000000,
  parameter int REPEAT_CYCLES     = 20000000,
  parameter int FIFO_DEPTH        = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [4:0]                    debounced_btn,
  input  logic                          enable,
  output logic                          evt_valid,
  input  logic                          evt_ready,
  output logic [4:0]                    evt_code,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow,
  input  logic                          overflow_clr
);
  localparam int NB     = 5;
  localparam int MAX_LR = (LONG_PRESS_CYCLES > REPEAT_CYCLES) ? LONG_PRESS_CYCLES : REPEAT_CYCLES;
  localparam int CW     = $clog2((MAX_LR > 2) ? MAX_LR : 2);
  localparam int AW     = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] LONG_LAST = CW'(LONG_PRESS_CYCLES - 1);
  localparam logic [CW-1:0] RPT_LAST  = CW'((REPEAT_CYCLES > 0) ? REPEAT_CYCLES - 1 : 0);
  localparam logic [1:0] T_PRESS = 2'd0, T_RELEASE = 2'd1, T_LONG = 2'd2, T_REPEAT = 2'd3;

  typedef enum logic [1:0] {S_IDLE, S_HELD, S_RPT} btn_state_e;

  btn_state_e    state_q [NB];
  btn_state_e    state_d [NB];
  logic [CW-1:0] cnt_q [NB];
  logic [CW-1:0] cnt_d [NB];
  logic [3:0]    pend_q [NB];
  logic [3:0]    pend_d [NB];
  logic [4:0]    mem_q [FIFO_DEPTH];
  logic [4:0]    mem_d [FIFO_DEPTH];
  logic [4:0]    prev_btn_q, prev_btn_d;
  logic          primed_q, primed_d;
  logic [2:0]    rr_ptr_q, rr_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          overflow_q, overflow_d;

  logic [3:0]    raise [NB];
  logic [4:0]    rise, fall;
  logic          push, pop, full, merge;
  logic [2:0]    gnt_btn;
  logic [1:0]    gnt_type;

  // Edge detection is suppressed until prev_btn has captured one real sample.
  always_comb begin
    rise       = primed_q ? (debounced_btn & ~prev_btn_q) : 5'd0;
    fall       = primed_q ? (~debounced_btn & prev_btn_q) : 5'd0;
    prev_btn_d = debounced_btn;
    primed_d   = 1'b1;
    for (int b = 0; b < NB; b++) begin
      state_d[b] = state_q[b];
      cnt_d[b]   = cnt_q[b];
      raise[b]   = 4'd0;
      if (!enable) begin
        state_d[b] = S_IDLE;
        cnt_d[b]   = '0;
      end else begin
        case (state_q[b])
          S_IDLE: if (rise[b]) begin
            raise[b][T_PRESS] = 1'b1;
            cnt_d[b]          = '0;
            state_d[b]        = S_HELD;
          end
          S_HELD: if (fall[b]) begin
            raise[b][T_RELEASE] = 1'b1;
            cnt_d[b]            = '0;
            state_d[b]          = S_IDLE;
          end else if (cnt_q[b] == LONG_LAST) begin
            raise[b][T_LONG] = 1'b1;
            cnt_d[b]         = '0;
            state_d[b]       = S_RPT;
          end else begin
            cnt_d[b] = cnt_q[b] + CW'(1);
          end
          S_RPT: if (fall[b]) begin
            raise[b][T_RELEASE] = 1'b1;
            cnt_d[b]            = '0;
            state_d[b]          = S_IDLE;
          end else if (REPEAT_CYCLES != 0) begin
            if (cnt_q[b] == RPT_LAST) begin
              raise[b][T_REPEAT] = 1'b1;
              cnt_d[b]           = '0;
            end else begin
              cnt_d[b] = cnt_q[b] + CW'(1);
            end
          end
          default: state_d[b] = S_IDLE;
        endcase
      end
    end
  end

  // Round-robin grant over registered pending bits; only when the FIFO can take it.
  always_comb begin
    logic [3:0] sum;
    logic [2:0] idx;
    logic       found;
    pop      = (count_q != '0) && evt_ready;
    full     = (count_q == (AW+1)'(FIFO_DEPTH));
    found    = 1'b0;
    gnt_btn  = 3'd0;
    gnt_type = T_PRESS;
    sum      = 4'd0;
    idx      = 3'd0;
    if (!full || pop) begin
      for (int k = 0; k < NB; k++) begin
        sum = {1'b0, rr_ptr_q} + 4'(k);
        idx = (sum >= 4'd5) ? 3'(sum - 4'd5) : sum[2:0];
        if (!found && pend_q[idx] != 4'd0) begin
          found   = 1'b1;
          gnt_btn = idx;
          if (pend_q[idx][T_PRESS])       gnt_type = T_PRESS;
          else if (pend_q[idx][T_LONG])   gnt_type = T_LONG;
          else if (pend_q[idx][T_REPEAT]) gnt_type = T_REPEAT;
          else                            gnt_type = T_RELEASE;
        end
      end
    end
    push = found;
  end

  // A raise onto a bit that is still pending (and not leaving this cycle) is a lost event.
  always_comb begin
    merge = 1'b0;
    for (int b = 0; b < NB; b++) pend_d[b] = pend_q[b];
    if (push) pend_d[gnt_btn][gnt_type] = 1'b0;
    for (int b = 0; b < NB; b++) begin
      for (int t = 0; t < 4; t++) begin
        if (raise[b][t]) begin
          if (pend_d[b][t]) merge = 1'b1;
          pend_d[b][t] = 1'b1;
        end
      end
    end
    overflow_d = overflow_q;
    if (overflow_clr) overflow_d = 1'b0;
    if (merge)        overflow_d = 1'b1;
    rr_ptr_d = rr_ptr_q;
    if (push) rr_ptr_d = (gnt_btn == 3'd4) ? 3'd0 : gnt_btn + 3'd1;
    for (int i = 0; i < FIFO_DEPTH; i++) mem_d[i] = mem_q[i];
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = {gnt_type, gnt_btn};
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_btn_q <= 5'd0;
      primed_q   <= 1'b0;
      rr_ptr_q   <= 3'd0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      for (int b = 0; b < NB; b++) begin
        state_q[b] <= S_IDLE;
        cnt_q[b]   <= '0;
        pend_q[b]  <= 4'd0;
      end
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= 5'd0;
    end else begin
      prev_btn_q <= prev_btn_d;
      primed_q   <= primed_d;
      rr_ptr_q   <= rr_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      for (int b = 0; b < NB; b++) begin
        state_q[b] <= state_d[b];
        cnt_q[b]   <= cnt_d[b];
        pend_q[b]  <= pend_d[b];
      end
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= mem_d[i];
    end
  end

  // Valid/ready: a transfer happens on a clock edge where evt_valid and evt_ready
  // are both high; the head entry is held unchanged while evt_valid & !evt_ready.
  assign evt_valid  = (count_q != '0);
  assign evt_code   = mem_q[rd_ptr_q];
  assign fifo_count = count_q;
  assign overflow   = overflow_q;
endmodule

// File: tb/tb_button_event_arbiter.sv
// Bench for button_event_arbiter: an event-level model (hold ages, pending set,
// queue) checked every cycle, plus directed scenarios with literal expectations.
module tb_button_event_arbiter;
  localparam int L = 10;
  localparam int R = 4;
  localparam int D = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] debounced_btn = 5'd0;
  logic       enable = 1'b1;
  logic       evt_valid;
  logic       evt_ready = 1'b1;
  logic [4:0] evt_code;
  logic [2:0] fifo_count;
  logic       overflow;
  logic       overflow_clr = 1'b0;

  button_event_arbiter #(.LONG_PRESS_CYCLES(L), .REPEAT_CYCLES(R), .FIFO_DEPTH(D)) dut (
    .clk(clk), .rst(rst), .debounced_btn(debounced_btn), .enable(enable),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_code(evt_code),
    .fifo_count(fifo_count), .overflow(overflow), .overflow_clr(overflow_clr)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int n_prints = 0;
  int cyc      = 0;

  // Behavioural model: events by hold age, pending set per button, queue for the FIFO.
  logic [4:0] mdl_fifo[$];
  logic [3:0] m_pend[5] = '{default: 4'd0};
  logic [3:0] newp[5];
  logic       m_trk[5] = '{default: 1'b0};
  int         m_age[5] = '{default: 0};
  int         m_rr = 0;
  logic       m_ovf = 1'b0;
  logic [4:0] m_prev = 5'd0;
  logic       m_primed = 1'b0;
  int         prio[4] = '{0, 2, 3, 1};

  always @(posedge clk or posedge rst) begin
    logic pop_m, can_push, gnt, set_ovf, rise, fall;
    int   gb, gt, b;
    logic [3:0] r;
    if (rst) begin
      mdl_fifo.delete();
      m_ovf = 1'b0; m_rr = 0; m_primed = 1'b0; m_prev = 5'd0;
      for (int i = 0; i < 5; i++) begin m_pend[i] = 4'd0; m_trk[i] = 1'b0; m_age[i] = 0; end
    end else begin
      pop_m    = (mdl_fifo.size() != 0) && evt_ready;
      can_push = (mdl_fifo.size() < D) || pop_m;
      gnt = 1'b0; gb = 0; gt = 0; set_ovf = 1'b0;
      if (can_push) begin
        for (int k = 0; k < 5; k++) begin
          b = (m_rr + k) % 5;
          if (!gnt && m_pend[b] != 4'd0) begin
            gnt = 1'b1; gb = b;
            for (int p = 3; p >= 0; p--) if (m_pend[b][prio[p]]) gt = prio[p];
          end
        end
      end
      for (int i = 0; i < 5; i++) newp[i] = m_pend[i];
      if (gnt) begin newp[gb][gt] = 1'b0; m_rr = (gb + 1) % 5; end
      for (int i = 0; i < 5; i++) begin
        r = 4'd0;
        if (!enable) m_trk[i] = 1'b0;
        else if (m_primed) begin
          rise = debounced_btn[i] && !m_prev[i];
          fall = !debounced_btn[i] && m_prev[i];
          if (!m_trk[i]) begin
            if (rise) begin r[0] = 1'b1; m_trk[i] = 1'b1; m_age[i] = 0; end
          end else if (fall) begin
            r[1] = 1'b1; m_trk[i] = 1'b0;
          end else begin
            m_age[i]++;
            if (m_age[i] == L) r[2] = 1'b1;
            else if (m_age[i] > L && R != 0 && (m_age[i] - L) % R == 0) r[3] = 1'b1;
          end
        end
        for (int t = 0; t < 4; t++) if (r[t]) begin
          if (newp[i][t]) set_ovf = 1'b1;
          newp[i][t] = 1'b1;
        end
      end
      for (int i = 0; i < 5; i++) m_pend[i] = newp[i];
      m_prev = debounced_btn; m_primed = 1'b1;
      if (overflow_clr) m_ovf = 1'b0;
      if (set_ovf) m_ovf = 1'b1;
      if (pop_m) void'(mdl_fifo.pop_front());
      if (gnt) mdl_fifo.push_back({2'(gt), 3'(gb)});
    end
  end

  // Accepted-event log used by the directed checks.
  logic [4:0] got_q[$];
  int         got_cyc[$];
  logic [4:0] exp_q[$];

  always @(negedge clk) begin
    logic       ev;
    logic [4:0] ec;
    cyc++;
    ev = (mdl_fifo.size() != 0);
    ec = ev ? mdl_fifo[0] : 5'd0;
    n_checks++;
    if (evt_valid !== ev || (ev && evt_code !== ec) ||
        fifo_count !== 3'(mdl_fifo.size()) || overflow !== m_ovf) begin
      if (n_prints < 20)
        $display("FAIL model_cycle %0d: got v=%b code=%h cnt=%0d ovf=%b, want v=%b code=%h cnt=%0d ovf=%b",
                 cyc, evt_valid, evt_code, fifo_count, overflow, ev, ec, mdl_fifo.size(), m_ovf);
      n_prints++;
    end else n_pass++;
    if (evt_valid === 1'b1 && evt_ready) begin
      got_q.push_back(evt_code);
      got_cyc.push_back(cyc);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic check_val(input string nm, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  task automatic check_seq(input string nm);
    bit    ok;
    string sa, se;
    ok = (got_q.size() == exp_q.size());
    sa = ""; se = "";
    foreach (got_q[i]) sa = {sa, $sformatf("%h ", got_q[i])};
    foreach (exp_q[i]) begin
      se = {se, $sformatf("%h ", exp_q[i])};
      if (i < got_q.size() && got_q[i] !== exp_q[i]) ok = 1'b0;
    end
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got [%s] expected [%s]", nm, sa, se);
  endtask

  function automatic int cyc_at(input int i);
    return (i < got_cyc.size()) ? got_cyc[i] : -1;
  endfunction

  function automatic void clear_log();
    got_q.delete();
    got_cyc.delete();
  endfunction

  initial begin
    int c0, c1;
    tick(3);
    check_val("reset_valid", int'(evt_valid), 0);
    check_val("reset_code", int'(evt_code), 0);
    check_val("reset_count", int'(fifo_count), 0);
    check_val("reset_overflow", int'(overflow), 0);
    rst = 1'b0;
    tick(3);

    // Short tap on btn2
    clear_log(); c0 = cyc;
    debounced_btn = 5'b00100; tick(3);
    debounced_btn = 5'b00000; tick(6);
    exp_q = '{5'h02, 5'h0A};
    check_seq("tap_btn2_seq");
    check_val("tap_press_latency", cyc_at(0), c0 + 3);
    check_val("tap_release_latency", cyc_at(1), c0 + 6);

    // Long hold on btn0
    clear_log(); c0 = cyc;
    debounced_btn = 5'b00001; tick(20);
    debounced_btn = 5'b00000; tick(8);
    exp_q = '{5'h00, 5'h10, 5'h18, 5'h18, 5'h08};
    check_seq("hold_btn0_seq");
    check_val("hold_long_cycle", cyc_at(1), c0 + 13);
    check_val("hold_repeat1_cycle", cyc_at(2), c0 + 17);
    check_val("hold_repeat2_cycle", cyc_at(3), c0 + 21);
    check_val("hold_release_cycle", cyc_at(4), c0 + 23);

    // Simultaneous presses and round-robin rotation
    rst = 1'b1; tick(2); rst = 1'b0; tick(2);
    clear_log(); c0 = cyc;
    debounced_btn = 5'b10011; tick(4);
    debounced_btn = 5'b00000; tick(6);
    debounced_btn = 5'b00100; tick(3);
    debounced_btn = 5'b00000; tick(6);
    debounced_btn = 5'b01001; tick(4);
    debounced_btn = 5'b00000; tick(6);
    exp_q = '{5'h00, 5'h01, 5'h04, 5'h08, 5'h09, 5'h0C, 5'h02, 5'h0A, 5'h03, 5'h00, 5'h0B, 5'h08};
    check_seq("round_robin_seq");
    check_val("rr_first_cycle", cyc_at(0), c0 + 3);
    check_val("rr_second_cycle", cyc_at(1), c0 + 4);
    check_val("rr_third_cycle", cyc_at(2), c0 + 5);

    // Back-pressure, saturation and merge overflow
    clear_log(); evt_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      debounced_btn = 5'b01000; tick(2);
      debounced_btn = 5'b00000; tick(2);
    end
    tick(2);
    check_val("bp_count", int'(fifo_count), 4);
    check_val("bp_valid", int'(evt_valid), 1);
    check_val("bp_code", int'(evt_code), 5'h03);
    check_val("bp_overflow", int'(overflow), 1);
    evt_ready = 1'b1; tick(10);
    exp_q = '{5'h03, 5'h0B, 5'h03, 5'h0B, 5'h03, 5'h0B};
    check_seq("bp_drain_seq");
    check_val("bp_overflow_sticky", int'(overflow), 1);
    overflow_clr = 1'b1; tick(1);
    overflow_clr = 1'b0; tick(1);
    check_val("bp_overflow_clr", int'(overflow), 0);
    check_val("bp_empty_after", int'(fifo_count), 0);

    // Reset mid-hold on btn1
    debounced_btn = 5'b00010; tick(5);
    rst = 1'b1; clear_log(); tick(2);
    rst = 1'b0; tick(15);
    debounced_btn = 5'b00000; tick(5);
    exp_q.delete();
    check_seq("reset_hold_no_events");
    check_val("reset_hold_overflow", int'(overflow), 0);

    // Enable low while btn2 goes down, then re-enable while held
    clear_log();
    enable = 1'b0; debounced_btn = 5'b00100; tick(3);
    enable = 1'b1; tick(12);
    debounced_btn = 5'b00000; tick(3);
    c1 = cyc;
    debounced_btn = 5'b00100; tick(3);
    debounced_btn = 5'b00000; tick(6);
    exp_q = '{5'h02, 5'h0A};
    check_seq("enable_seq");
    check_val("enable_repress_latency", cyc_at(0), c1 + 3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
